alu_issue_ctrl: RTL and testbench

- Upstream issue stage for the combinational 8-bit ALU.
- Accepts operation requests over a valid/ready channel and buffers them in a small FIFO.
- Drives the ALU's A/B/ALU_Sel inputs one operation at a time from registers, captures ALU_Out/CarryOut, and returns each result over a valid/ready response channel.
- Gives the purely combinational ALU a clocked, back-pressured interface for the rest of the datapath and for the class-based bench.

---
 rtl/alu_issue_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: clocked, back-pressured issue stage in front of the
// combinational 8-bit ALU. Requests queue in a DEPTH-entry FIFO; a small FSM
// loads one operation at a time into registered ALU inputs, waits one cycle for
// the ALU to settle, then captures the result and holds it on a valid/ready
// response channel until it is taken.
//
// Optional build macro: ALU_ISSUE_ZERO_FLAG_EN adds the rsp_zero output, which
// is captured with the response and is 1 when the captured ALU_Out is zero.
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [3:0]       rsp_sel
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic             rsp_zero
`endif
);

  // Pointer and occupancy widths; DEPTH is a power of two so pointers wrap
  // naturally on overflow.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [3:0]       sel;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rdy_en_q, rdy_en_d;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [3:0]       rsp_sel_q, rsp_sel_d;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic             rsp_zero_q, rsp_zero_d;
`endif

  req_t             mem_q [DEPTH];
  req_t             head;
  req_t             req_in;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             load;
  logic             capture;
  logic             release_rsp;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // rdy_en_q keeps req_ready low during reset and lets it rise on the first
  // clock after release. Full is judged on the registered count only, so a
  // full FIFO never accepts in the same cycle it pops.
  assign fifo_empty = (count_q == '0);
  assign req_ready  = rdy_en_q && (count_q != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign pop        = load;
  assign head       = mem_q[rd_ptr_q];

  // Pack the incoming request into a FIFO entry.
  always_comb begin
    req_in     = '0;
    req_in.a   = req_a;
    req_in.b   = req_b;
    req_in.sel = req_sel;
  end

  // FIFO storage: entries are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_in;
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdy_en_d = 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  // Next state and per-cycle actions. The RESP decision looks at the count
  // before any same-cycle push, so a request arriving into an empty FIFO
  // waits for the following IDLE decision.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU input registers: change only on load so ALU_Out is settled by capture.
  always_comb begin
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    if (load) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.sel;
    end
  end

  // Response registers: captured at the end of EXEC, held until handshake.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sel_d    = rsp_sel_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    rsp_zero_d   = rsp_zero_q;
`endif
    if (capture) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_out;
      rsp_carry_d  = alu_carry;
      rsp_sel_d    = alu_sel_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_d   = (alu_out == '0);
`endif
    end else if (release_rsp) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control, pointer and FSM state registers; reset discards all queued work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // ALU operand registers; cleared on reset so the ALU sees a known operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else begin
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  // Response registers; cleared on reset so no stale result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_sel_q    <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sel_q    <= rsp_sel_d;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_q   <= rsp_zero_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sel    = rsp_sel_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  assign rsp_zero   = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the
// combinational ALU hooked to the alu_* ports.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic [3:0] rsp_sel;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic       rsp_zero;
`endif

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_sel    (rsp_sel)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    .rsp_zero   (rsp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: CarryOut is the carry of A+B regardless of select.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = alu_sum[8];
    case (alu_sel)
      4'b0000: alu_out = alu_sum[7:0];
      4'b0001: alu_out = alu_a - alu_b;
      4'b0100: alu_out = alu_a << 1;
      4'b0101: alu_out = alu_a >> 1;
      4'b1000: alu_out = alu_a & alu_b;
      4'b1001: alu_out = alu_a | alu_b;
      4'b1010: alu_out = alu_a ^ alu_b;
      default: alu_out = alu_sum[7:0];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int sent;
  int rcv;
  int cyc;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    check("rst_rsp_sel", rsp_sel, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", req_ready, 1);

    // Single add FF+01 with latency check
    req_valid = 1'b1; req_a = 8'hFF; req_b = 8'h01; req_sel = 4'b0000;
    tick();
    req_valid = 1'b0;
    check("add_k_valid", rsp_valid, 0);
    tick();
    check("add_k1_alu_a", alu_a, 8'hFF);
    check("add_k1_alu_b", alu_b, 8'h01);
    check("add_k1_alu_sel", alu_sel, 4'b0000);
    check("add_k1_valid", rsp_valid, 0);
    tick();
    check("add_k2_valid", rsp_valid, 1);
    check("add_result", rsp_result, 8'h00);
    check("add_carry", rsp_carry, 1);
    check("add_sel", rsp_sel, 4'b0000);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("add_zero", rsp_zero, 1);
`endif
    rsp_ready = 1'b1;
    tick();
    check("add_released", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Shift-left 81 -> 02, then hold response for 10 cycles
    req_valid = 1'b1; req_a = 8'h81; req_b = 8'h00; req_sel = 4'b0100;
    tick();
    req_valid = 1'b0;
    tick();
    check("shl_exec_alu_sel", alu_sel, 4'b0100);
    check("shl_exec_alu_a", alu_a, 8'h81);
    tick();
    check("shl_valid", rsp_valid, 1);
    check("shl_result", rsp_result, 8'h02);
    check("shl_carry", rsp_carry, 0);
    check("shl_sel", rsp_sel, 4'b0100);
    check("shl_alu_sel_stable", alu_sel, 4'b0100);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("shl_zero", rsp_zero, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, 8'h02);
      check("hold_carry", rsp_carry, 0);
      check("hold_sel", rsp_sel, 4'b0100);
    end
    rsp_ready = 1'b1;
    tick();
    check("hold_released", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_duplicate", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Back-pressure: 6 offered, 5 accepted, then drained in order
    for (int i = 1; i <= 6; i++) begin
      req_valid = 1'b1; req_a = 8'(i); req_b = 8'h00; req_sel = 4'b0000;
      check("bp_req_ready", req_ready, (i <= 5) ? 1 : 0);
      tick();
    end
    req_valid = 1'b0;
    check("bp_full_ready", req_ready, 0);
    rsp_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      check("bp_drain_valid", rsp_valid, 1);
      check("bp_drain_result", rsp_result, n);
      tick();
      check("bp_drain_gap", rsp_valid, 0);
      tick();
    end
    check("bp_drain_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Async reset during EXEC with 3 requests queued
    req_valid = 1'b1; req_a = 8'h20; req_b = 8'h01; req_sel = 4'b0000;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("ar_first_result", rsp_result, 8'h21);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_a = 8'(8'h30 + i); req_b = 8'h00; req_sel = 4'b0000;
      tick();
    end
    req_valid = 1'b0;
    check("ar_full", req_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ar_exec_alu_a", alu_a, 8'h30);
    check("ar_exec_valid", rsp_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_alu_a", alu_a, 0);
    check("ar_alu_b", alu_b, 0);
    check("ar_alu_sel", alu_sel, 0);
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_rsp_result", rsp_result, 0);
    check("ar_rsp_carry", rsp_carry, 0);
    check("ar_rsp_sel", rsp_sel, 0);
    check("ar_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_ready_after_release", req_ready, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ar_no_response", rsp_valid, 0);
    end
    check("ar_alu_a_idle", alu_a, 0);

    // Streaming 20 requests with random req_valid, rsp_ready held high
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 400) begin
      req_valid = (sent < 20) && ($urandom_range(0, 1) == 1);
      req_a     = 8'(sent * 37 + 5);
      req_b     = 8'(sent * 11 + 200);
      req_sel   = 4'b0000;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_rsp", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("stream_rsp", {rsp_carry, rsp_result}, exp_v);
        end
        rcv++;
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({1'b0, req_a} + {1'b0, req_b});
        sent++;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    check("stream_count", rcv, 20);
    check("stream_sent", sent, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
